// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Pipeline hazard control. The unit keeps its own copy of the EXE and MEM
//   occupants (op type, rd, store-data source) and sees only the ID stage.
//   From that state it produces forwarding selects, load-use stalls, a
//   load-to-store data forward and branch flushes. A multi-cycle MUL/DIV
//   holds EXE for MULDIV_LAT cycles and freezes the front end meanwhile.
//
//   Optional build macro: HAZARD_PERF_CNT_EN enables the three stall/flush
//   performance counters. When it is undefined the perf ports are tied to 0.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   optype_ID                       0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 MULDIV
//   rs1use_ID, rs2use_ID            ID reads rs1 / rs2
//   rs1_ID, rs2_ID, rd_ID           ID register addresses
//   branch_taken_ID                 branch/jump resolved taken in ID
//   pc_en_IF                        PC update enable
//   reg_FD_stall, reg_FD_flush      IF/ID hold / clear
//   reg_DE_en, reg_DE_flush         ID/EX enable / bubble insert
//   reg_EM_flush                    EX/MEM bubble insert
//   forward_ctrl_A, forward_ctrl_B  0 regfile, 1 EXE, 2 MEM ALU/MULDIV, 3 MEM load
//   forward_ctrl_ls                 MEM load data as store data in EXE
//   muldiv_busy                     MULDIV in EXE, not in its final cycle
//   perf_load_stall, perf_muldiv_stall, perf_br_flush   performance counters
module hazard_scoreboard_unit #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        optype_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              branch_taken_ID,
  output logic              pc_en_IF,
  output logic              reg_FD_stall,
  output logic              reg_FD_flush,
  output logic              reg_DE_en,
  output logic              reg_DE_flush,
  output logic              reg_EM_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              muldiv_busy,
  output logic [CNT_W-1:0]  perf_load_stall,
  output logic [CNT_W-1:0]  perf_muldiv_stall,
  output logic [CNT_W-1:0]  perf_br_flush
);

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_MULDIV = 3'd4;

  // cnt only needs to hold MULDIV_LAT-1; keep at least one bit for LAT=1.
  localparam int          CW       = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 1);

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs2;
  } exe_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
  } mem_t;

  exe_t          exe_q, exe_d;
  mem_t          mem_q;
  logic [CW-1:0] cnt;
  logic [2:0]    op_id;

  logic hit1_exe, hit2_exe, hit1_mem, hit2_mem;
  logic exe_fwd, mem_alu, mem_ld, load_stall;

  // Reserved encodings 5-7 behave as NONE from here on.
  always_comb op_id = (optype_ID > OP_MULDIV) ? OP_NONE : optype_ID;

  assign hit1_exe = rs1use_ID && (rs1_ID == exe_q.rd) && (exe_q.rd != '0);
  assign hit2_exe = rs2use_ID && (rs2_ID == exe_q.rd) && (exe_q.rd != '0);
  assign hit1_mem = rs1use_ID && (rs1_ID == mem_q.rd) && (mem_q.rd != '0);
  assign hit2_mem = rs2use_ID && (rs2_ID == mem_q.rd) && (mem_q.rd != '0);

  assign muldiv_busy = (exe_q.op == OP_MULDIV) && (cnt != '0);

  // An EXE result is forwardable from ALU, or from MULDIV in its final cycle.
  assign exe_fwd = (exe_q.op == OP_ALU) || ((exe_q.op == OP_MULDIV) && (cnt == '0));
  assign mem_alu = (mem_q.op == OP_ALU) || (mem_q.op == OP_MULDIV);
  assign mem_ld  = (mem_q.op == OP_LOAD);

  function automatic logic [1:0] fwd_sel(input logic he, input logic hm,
                                         input logic ef, input logic ma,
                                         input logic ml);
    if (he && ef)      return 2'd1;
    else if (hm && ma) return 2'd2;
    else if (hm && ml) return 2'd3;
    else               return 2'd0;
  endfunction

  assign forward_ctrl_A = fwd_sel(hit1_exe, hit1_mem, exe_fwd, mem_alu, mem_ld);
  assign forward_ctrl_B = fwd_sel(hit2_exe, hit2_mem, exe_fwd, mem_alu, mem_ld);

  // A store's data operand does not stall: it is picked up from MEM next
  // cycle through forward_ctrl_ls. Its address operand must stall.
  assign load_stall = (exe_q.op == OP_LOAD) &&
                      (hit1_exe || (hit2_exe && (op_id != OP_STORE)));

  assign forward_ctrl_ls = (exe_q.op == OP_STORE) && mem_ld &&
                           (exe_q.rs2 == mem_q.rd) && (mem_q.rd != '0);

  // muldiv_busy dominates a load stall: EXE holds, so no bubble goes in.
  assign reg_DE_flush = load_stall && !muldiv_busy;
  assign reg_DE_en    = !muldiv_busy;
  assign reg_EM_flush = muldiv_busy;
  assign reg_FD_stall = load_stall || muldiv_busy;
  assign pc_en_IF     = !(load_stall || muldiv_busy);
  // A branch decided under a stall is re-evaluated later, so stall wins.
  assign reg_FD_flush = branch_taken_ID && !load_stall && !muldiv_busy;

  always_comb begin
    exe_d     = '0;
    if (!reg_DE_flush) begin
      exe_d.op  = op_id;
      exe_d.rd  = rd_ID;
      exe_d.rs2 = rs2_ID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q <= '0;
      mem_q <= '0;
      cnt   <= '0;
    end else if (muldiv_busy) begin
      mem_q <= '0;
      cnt   <= cnt - CW'(1);
    end else begin
      exe_q    <= exe_d;
      mem_q.op <= exe_q.op;
      mem_q.rd <= exe_q.rd;
      cnt      <= (exe_d.op == OP_MULDIV) ? CNT_LOAD : '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] pc_ld, pc_md, pc_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ld <= '0;
      pc_md <= '0;
      pc_br <= '0;
    end else begin
      if (reg_DE_flush) pc_ld <= pc_ld + CNT_W'(1);
      if (muldiv_busy)  pc_md <= pc_md + CNT_W'(1);
      if (reg_FD_flush) pc_br <= pc_br + CNT_W'(1);
    end
  end

  assign perf_load_stall   = pc_ld;
  assign perf_muldiv_stall = pc_md;
  assign perf_br_flush     = pc_br;
`else
  assign perf_load_stall   = '0;
  assign perf_muldiv_stall = '0;
  assign perf_br_flush     = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit. The driver applies one ID
// vector per cycle and queues the hand-computed control word it expects;
// the monitor pops and compares on the falling edge.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  optype_ID;
  logic        rs1use_ID, rs2use_ID;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic        branch_taken_ID;
  logic        pc_en_IF, reg_FD_stall, reg_FD_flush, reg_DE_en, reg_DE_flush;
  logic        reg_EM_flush, forward_ctrl_ls, muldiv_busy;
  logic [1:0]  forward_ctrl_A, forward_ctrl_B;
  logic [31:0] perf_load_stall, perf_muldiv_stall, perf_br_flush;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .optype_ID(optype_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .branch_taken_ID(branch_taken_ID),
    .pc_en_IF(pc_en_IF), .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush),
    .reg_DE_en(reg_DE_en), .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .muldiv_busy(muldiv_busy),
    .perf_load_stall(perf_load_stall), .perf_muldiv_stall(perf_muldiv_stall),
    .perf_br_flush(perf_br_flush)
  );

  typedef struct {
    string       nm;
    logic [11:0] ctl;
    bit          pchk;
    logic [31:0] pl, pm, pb;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Control word: {pc_en, fd_stall, fd_flush, de_en, de_flush, em_flush, fA, fB, ls, busy}
  function automatic logic [11:0] c(int pe, int fs, int ff, int de, int df,
                                    int ef, int fa, int fb, int ls, int bz);
    logic [11:0] r;
    r = {pe[0], fs[0], ff[0], de[0], df[0], ef[0], fa[1:0], fb[1:0], ls[0], bz[0]};
    return r;
  endfunction

  logic [11:0] IDLE, STALL, BUSY;

  task automatic step(input string nm, input int op, input int u1, input int r1,
                      input int u2, input int r2, input int rd, input int br,
                      input logic [11:0] e, input int pchk = 0,
                      input int pl = 0, input int pm = 0, input int pb = 0);
    exp_t x;
    optype_ID       = op[2:0];
    rs1use_ID       = u1[0];
    rs1_ID          = r1[4:0];
    rs2use_ID       = u2[0];
    rs2_ID          = r2[4:0];
    rd_ID           = rd[4:0];
    branch_taken_ID = br[0];
    x.nm   = nm;
    x.ctl  = e;
    x.pchk = pchk[0];
    x.pl   = pl;
    x.pm   = pm;
    x.pb   = pb;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_en_IF, reg_FD_stall, reg_FD_flush, reg_DE_en, reg_DE_flush,
               reg_EM_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
               muldiv_busy};
        n_chk++;
        if (act === e.ctl) n_pass++;
        else $display("FAIL %s: ctl {pe fs ff de df ef fA fB ls bz} got %b expected %b",
                      e.nm, act, e.ctl);
        if (e.pchk) begin
`ifndef HAZARD_PERF_CNT_EN
          e.pl = 0; e.pm = 0; e.pb = 0;
`endif
          n_chk++;
          if (perf_load_stall === e.pl && perf_muldiv_stall === e.pm &&
              perf_br_flush === e.pb)
            n_pass++;
          else
            $display("FAIL %s_perf: ld/md/br got %0d/%0d/%0d expected %0d/%0d/%0d",
                     e.nm, perf_load_stall, perf_muldiv_stall, perf_br_flush,
                     e.pl, e.pm, e.pb);
        end
      end
    end
  end

  initial begin : driver
    IDLE  = c(1,0,0,1,0,0,0,0,0,0);
    STALL = c(0,1,0,1,1,0,0,0,0,0);
    BUSY  = c(0,1,0,0,0,1,0,0,0,1);
    rst_n = 1'b0;
    optype_ID = '0; rs1use_ID = 0; rs2use_ID = 0;
    rs1_ID = '0; rs2_ID = '0; rd_ID = '0; branch_taken_ID = 0;
    @(posedge clk); #1;
    //   name          op u1 r1 u2 r2 rd br  expected
    step("reset",       0, 0, 0, 0, 0, 0, 0, IDLE, 1, 0, 0, 0);
    rst_n = 1'b1;
    // ALU forwarding from EXE then MEM
    step("alu_x5",      1, 0, 0, 0, 0, 5, 0, IDLE);
    step("fwdA_exe",    1, 1, 5, 0, 0, 9, 0, c(1,0,0,1,0,0,1,0,0,0));
    step("fwdA_mem",    0, 1, 5, 0, 0, 0, 0, c(1,0,0,1,0,0,2,0,0,0));
    // load-use on rs2
    step("ld_x6",       2, 0, 0, 0, 0, 6, 0, IDLE);
    step("ld_use_stall",1, 0, 0, 1, 6,10, 0, STALL);
    step("fwdB_load",   1, 0, 0, 1, 6,10, 0, c(1,0,0,1,0,0,0,3,0,0));
    // load then store data dependence: no stall, ls forward
    step("ld_x7",       2, 0, 0, 0, 0, 7, 0, IDLE);
    step("st_data_nostall",3,1,2, 1, 7, 0, 0, IDLE);
    step("fwd_ls",      0, 0, 0, 0, 0, 0, 0, c(1,0,0,1,0,0,0,0,1,0));
    // load then store address dependence: stall
    step("ld_x7b",      2, 0, 0, 0, 0, 7, 0, IDLE);
    step("st_addr_stall",3,1,7, 1, 3, 0, 0, STALL);
    step("st_addr_fwd", 3, 1, 7, 1, 3, 0, 0, c(1,0,0,1,0,0,3,0,0,0));
    // MULDIV occupancy
    step("md_x8",       4, 0, 0, 0, 0, 8, 0, IDLE);
    step("md_busy1",    1, 1, 8, 0, 0,11, 0, BUSY);
    step("md_busy2",    1, 1, 8, 0, 0,11, 0, BUSY);
    step("md_busy3",    1, 1, 8, 0, 0,11, 0, BUSY);
    step("md_final_fwd",1, 1, 8, 0, 0,11, 0, c(1,0,0,1,0,0,1,0,0,0), 1, 2, 3, 0);
    step("md_mem_fwd",  0, 1, 8, 0, 0, 0, 0, c(1,0,0,1,0,0,2,0,0,0));
    // branch during load-use stall
    step("ld_x12",      2, 0, 0, 0, 0,12, 0, IDLE);
    step("br_in_stall", 1, 1,12, 0, 0,13, 1, STALL);
    step("br_after",    1, 1,12, 0, 0,13, 1, c(1,0,1,1,0,0,3,0,0,0));
    step("perf_mid",    0, 0, 0, 0, 0, 0, 0, IDLE, 1, 3, 3, 1);
    // x0 never forwards; reserved opcode behaves as NONE
    step("alu_x0",      1, 0, 0, 0, 0, 0, 0, IDLE);
    step("x0_nofwd",    0, 1, 0, 1, 0, 0, 0, IDLE);
    step("op6_x14",     6, 0, 0, 0, 0,14, 0, IDLE);
    step("op6_nofwd",   1, 1,14, 0, 0, 0, 0, IDLE);
    // reset in the middle of a MULDIV
    step("md_x15",      4, 0, 0, 0, 0,15, 0, IDLE);
    step("md_busy_pre", 0, 0, 0, 0, 0, 0, 0, BUSY);
    rst_n = 1'b0;
    step("rst_mid_md",  0, 0, 0, 0, 0, 0, 0, IDLE, 1, 0, 0, 0);
    rst_n = 1'b1;
    step("post_rst",    1, 1,15, 0, 0, 0, 0, IDLE);
    step("br_flush",    0, 0, 0, 0, 0, 0, 1, c(1,0,1,1,0,0,0,0,0,0));
    step("tail",        0, 0, 0, 0, 0, 0, 0, IDLE);
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: queue holds %0d entries, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the core's hazard detection unit.
- Tracks in-flight destination registers and op types for EXE and MEM internally; inputs come only from ID.
- Generates forwarding selects, load-use stalls, a load-to-store data forward and branch flushes.
- Adds a multi-cycle MUL/DIV unit that occupies EXE for MULDIV_LAT cycles and freezes the front end meanwhile.

Parameters:
- REG_AW, 5, register-address width.
- MULDIV_LAT, 4, cycles a MULDIV op occupies EXE; legal values >= 1.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- optype_ID  in  3  0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 MULDIV; 5-7 treated as NONE.
- rs1use_ID, rs2use_ID  in  1 each  ID reads rs1 / rs2.
- rs1_ID, rs2_ID, rd_ID  in  REG_AW each  ID register addresses.
- branch_taken_ID  in  1  branch/jump resolved taken in ID.
- pc_en_IF  out  1  PC update enable.
- reg_FD_stall, reg_FD_flush  out  1 each  IF/ID hold / clear.
- reg_DE_en, reg_DE_flush  out  1 each  ID/EX enable / bubble insert.
- reg_EM_flush  out  1  EX/MEM bubble insert.
- forward_ctrl_A, forward_ctrl_B  out  2 each  0 regfile, 1 EXE result, 2 MEM ALU/MULDIV result, 3 MEM load data.
- forward_ctrl_ls  out  1  select MEM load data as store data in EXE.
- muldiv_busy  out  1  MULDIV in EXE, not in its final cycle.
- perf_load_stall, perf_muldiv_stall, perf_br_flush  out  CNT_W each  counters (see Optional Feature).

Behaviour:
- Tracking registers: opt_EXE, rd_EXE, rs2_EXE, opt_MEM, rd_MEM, plus a muldiv counter cnt. All reset asynchronously to 0.
- With all tracking registers 0, every output is 0 except pc_en_IF=1 and reg_DE_en=1.
- muldiv_busy = (opt_EXE==MULDIV) && (cnt != 0).
- cnt loads MULDIV_LAT-1 on the edge where a MULDIV enters EXE, then decrements while nonzero.
- With MULDIV_LAT=1, cnt stays 0 and MULDIV timing equals ALU timing.
- While muldiv_busy:
  - EXE holds: reg_DE_en=0.
  - MEM receives a bubble: reg_EM_flush=1, opt_MEM <= NONE.
  - Front end freezes: pc_en_IF=0, reg_FD_stall=1.
- Otherwise:
  - opt_EXE/rd_EXE/rs2_EXE <= ID values, forced to NONE when reg_DE_flush.
  - opt_MEM/rd_MEM <= EXE values.
- hit1X = rs1use_ID && rs1_ID==rdX && rdX!=0 (X is EXE or MEM). hit2X is the same for rs2.
- forward_ctrl_A, EXE has priority over MEM:
  - 1 if hit1EXE and (opt_EXE==ALU, or opt_EXE==MULDIV && cnt==0);
  - else 2 if hit1MEM and opt_MEM is ALU or MULDIV;
  - else 3 if hit1MEM and opt_MEM==LOAD;
  - else 0.
- forward_ctrl_B uses the same rules with hit2.
- load_stall = opt_EXE==LOAD && (hit1EXE || (hit2EXE && optype_ID!=STORE)).
  - A store's rs1 (address) dependence stalls.
  - A store's rs2 (data) dependence does not stall; it is covered by forward_ctrl_ls next cycle.
- On load_stall: pc_en_IF=0, reg_FD_stall=1, reg_DE_flush=1.
- forward_ctrl_ls = opt_EXE==STORE && opt_MEM==LOAD && rs2_EXE==rd_MEM && rd_MEM!=0.
- reg_FD_flush = branch_taken_ID && !load_stall && !muldiv_busy. A stalled branch's decision is not final, so stall wins over flush.
- load_stall and muldiv_busy together: muldiv_busy dominates, so reg_DE_flush=0 and EXE holds.
- Forwarding outputs are purely combinational from ID inputs and tracking registers (zero latency).
- Reset asserted mid-MULDIV clears cnt and all tracking immediately. The first cycle after release behaves as an empty pipeline.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three CNT_W counters reset to 0 and wrap at 2^CNT_W:
  - perf_load_stall: +1 per load_stall cycle not masked by muldiv_busy.
  - perf_muldiv_stall: +1 per muldiv_busy cycle.
  - perf_br_flush: +1 per cycle with reg_FD_flush=1.
- When undefined, all three ports are tied to constant 0 and no counter logic is built.

Test Plan:
- ALU x5 into EXE, then ID uses rs1=5: forward_ctrl_A=1. One cycle later, with the MEM copy: forward_ctrl_A=2. No stall.
- LOAD x6, then ALU reading rs2=6: one cycle with pc_en_IF=0, reg_DE_flush=1. Next cycle forward_ctrl_B=3.
- LOAD x7, then STORE with rs2=7: no stall. Next cycle forward_ctrl_ls=1. Repeat with STORE rs1=7: one stall cycle.
- MULDIV_LAT=4, MULDIV x8 then ALU reading x8:
  - muldiv_busy=1 for 3 cycles, reg_EM_flush=1 each, FD held;
  - 4th cycle forward_ctrl_A=1;
  - with the perf feature, perf_muldiv_stall=3.
- branch_taken_ID=1 during a load-use stall: reg_FD_flush=0. On the following cycle: reg_FD_flush=1.
- rd=0 ALU followed by rs1=0 use: forward_ctrl_A=0. Assert rst_n=0 mid-MULDIV: muldiv_busy drops to 0 asynchronously.
